// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one fixed-latency memory port between two requesters (m0, m1).
// The ready cycle is never a grant edge, so a requester still holding valid there is not re-served.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_LAT = 1,
  parameter bit RR = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  m0_valid,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [31:0]           m0_wdata,
  input  logic [3:0]            m0_wmask,
  output logic [31:0]           m0_rdata,
  output logic                  m0_ready,
  input  logic                  m1_valid,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [31:0]           m1_wdata,
  input  logic [3:0]            m1_wmask,
  output logic [31:0]           m1_rdata,
  output logic                  m1_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_wmask,
  output logic                  mem_rstrb,
  input  logic [31:0]           mem_rdata,
  output logic                  busy,
  output logic [1:0]            gnt
);
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT} state_t;
  localparam logic [3:0] LAT = 4'(MEM_LAT);
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d, wmask_q, wmask_d;
  logic last_q, last_d, busy_q, busy_d, rstrb_q, rstrb_d, pick1;
  logic [1:0] gnt_q, gnt_d, rdy_q, rdy_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    last_d = last_q;
    busy_d = busy_q;
    gnt_d = gnt_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    wmask_d = 4'b0;
    rstrb_d = 1'b0;
    rdy_d = 2'b00;
    // last_q=1 means m1 was served last, so m0 wins the next tie
    pick1 = m1_valid && (!m0_valid || (RR && !last_q));
    case (state_q)
      IDLE: if ((m0_valid || m1_valid) && rdy_q == 2'b00) begin
        state_d = ACCESS;
        cnt_d = LAT;
        last_d = pick1;
        busy_d = 1'b1;
        gnt_d = pick1 ? 2'b10 : 2'b01;
        addr_d = (pick1 ? m1_addr : m0_addr) & ~ADDR_WIDTH'(3);
        wdata_d = pick1 ? m1_wdata : m0_wdata;
        wmask_d = pick1 ? m1_wmask : m0_wmask;
        rstrb_d = wmask_d == 4'b0;
      end
      default: begin
        cnt_d = cnt_q - 4'd1;
        state_d = WAIT;
        if (cnt_q == 4'd1) begin
          state_d = IDLE;
          rdy_d = gnt_q;
          gnt_d = 2'b00;
          busy_d = 1'b0;
        end
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q <= 4'd0;
      last_q <= 1'b1;
      busy_q <= 1'b0;
      gnt_q <= 2'b00;
      addr_q <= '0;
      wdata_q <= 32'd0;
      wmask_q <= 4'd0;
      rstrb_q <= 1'b0;
      rdy_q <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      last_q <= last_d;
      busy_q <= busy_d;
      gnt_q <= gnt_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      rstrb_q <= rstrb_d;
      rdy_q <= rdy_d;
    end
  end
  assign mem_addr = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wmask = wmask_q;
  assign mem_rstrb = rstrb_q;
  assign busy = busy_q;
  assign gnt = gnt_q;
  assign m0_ready = rdy_q[0];
  assign m1_ready = rdy_q[1];
  assign m0_rdata = rdy_q[0] ? mem_rdata : 32'd0;
  assign m1_rdata = rdy_q[1] ? mem_rdata : 32'd0;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of two arbiter builds (lat 1 round-robin, lat 3 fixed priority).
module tb_mem_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int checks = 0;
  int failures = 0;
  logic a_rst, a_m0_valid, a_m1_valid, a_m0_ready, a_m1_ready, a_rstrb, a_busy;
  logic [31:0] a_m0_addr, a_m1_addr, a_m0_wdata, a_m1_wdata, a_m0_rdata, a_m1_rdata;
  logic [31:0] a_mem_addr, a_mem_wdata, a_mem_rdata, a_raddr;
  logic [3:0] a_m0_wmask, a_m1_wmask, a_wmask;
  logic [1:0] a_gnt;
  logic b_rst, b_m0_valid, b_m1_valid, b_m0_ready, b_m1_ready, b_rstrb, b_busy;
  logic [31:0] b_m0_addr, b_m1_addr, b_m0_rdata, b_m1_rdata;
  logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata, b_raddr;
  logic [3:0] b_wmask;
  logic [1:0] b_gnt;
  logic [31:0] mem_a [0:63];
  mem_arbiter #(.ADDR_WIDTH(32), .MEM_LAT(1), .RR(1'b1)) u_a (
    .clk(clk), .reset(a_rst),
    .m0_valid(a_m0_valid), .m0_addr(a_m0_addr), .m0_wdata(a_m0_wdata), .m0_wmask(a_m0_wmask),
    .m0_rdata(a_m0_rdata), .m0_ready(a_m0_ready),
    .m1_valid(a_m1_valid), .m1_addr(a_m1_addr), .m1_wdata(a_m1_wdata), .m1_wmask(a_m1_wmask),
    .m1_rdata(a_m1_rdata), .m1_ready(a_m1_ready),
    .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_wmask(a_wmask), .mem_rstrb(a_rstrb),
    .mem_rdata(a_mem_rdata), .busy(a_busy), .gnt(a_gnt));
  mem_arbiter #(.ADDR_WIDTH(32), .MEM_LAT(3), .RR(1'b0)) u_b (
    .clk(clk), .reset(b_rst),
    .m0_valid(b_m0_valid), .m0_addr(b_m0_addr), .m0_wdata(32'd0), .m0_wmask(4'd0),
    .m0_rdata(b_m0_rdata), .m0_ready(b_m0_ready),
    .m1_valid(b_m1_valid), .m1_addr(b_m1_addr), .m1_wdata(32'd0), .m1_wmask(4'd0),
    .m1_rdata(b_m1_rdata), .m1_ready(b_m1_ready),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_wmask(b_wmask), .mem_rstrb(b_rstrb),
    .mem_rdata(b_mem_rdata), .busy(b_busy), .gnt(b_gnt));
  // Memory models: read data appears the cycle after the strobe and is held until the next read
  always @(posedge clk) begin
    if (a_rstrb) a_raddr <= a_mem_addr;
    for (int i = 0; i < 4; i++)
      if (a_wmask[i]) mem_a[a_mem_addr[7:2]][8*i +: 8] <= a_mem_wdata[8*i +: 8];
    if (b_rstrb) b_raddr <= b_mem_addr;
  end
  assign a_mem_rdata = mem_a[a_raddr[7:2]];
  assign b_mem_rdata = b_raddr ^ 32'hCAFE_0000;
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    for (int i = 0; i < 64; i++) mem_a[i] = 32'h1000_0000 + i;
    a_rst = 1'b0; b_rst = 1'b0;
    a_m0_valid = 1'b1; a_m1_valid = 1'b1;
    a_m0_addr = 32'h4; a_m1_addr = 32'h8;
    a_m0_wdata = 32'd0; a_m1_wdata = 32'd0; a_m0_wmask = 4'd0; a_m1_wmask = 4'd0;
    b_m0_valid = 1'b0; b_m1_valid = 1'b0; b_m0_addr = 32'h100; b_m1_addr = 32'h200;
    // T1: held in reset with both requesters valid
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t1_quiet", {23'd0, a_rstrb, a_wmask, a_m0_ready, a_m1_ready, a_busy, a_gnt}, 32'd0);
      chk("t1_addr", a_mem_addr, 32'd0);
    end
    // T2: single m0 read with an unaligned address
    a_m1_valid = 1'b0; a_m0_addr = 32'h13; a_rst = 1'b1;
    cyc();
    chk("t2_rstrb", {31'd0, a_rstrb}, 32'd1);
    chk("t2_addr", a_mem_addr, 32'h10);
    chk("t2_gnt_busy", {29'd0, a_busy, a_gnt}, 32'b101);
    cyc();
    chk("t2_ready", {30'd0, a_m1_ready, a_m0_ready}, 32'b01);
    chk("t2_rdata", a_m0_rdata, 32'h1000_0004);
    chk("t2_strobe_low", {31'd0, a_rstrb}, 32'd0);
    chk("t2_idle", {29'd0, a_busy, a_gnt}, 32'd0);
    a_m0_valid = 1'b0;
    cyc();
    chk("t2_ready_once", {30'd0, a_m1_ready, a_m0_ready}, 32'd0);
    // T3: round-robin under continuous contention right after reset
    a_rst = 1'b0;
    cyc();
    a_rst = 1'b1; a_m0_valid = 1'b1; a_m1_valid = 1'b1; a_m0_addr = 32'h4; a_m1_addr = 32'h8;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("t3_gnt", {30'd0, a_gnt}, (i % 2 == 0) ? 32'b01 : 32'b10);
      cyc();
      chk("t3_ready", {30'd0, a_m1_ready, a_m0_ready}, (i % 2 == 0) ? 32'b01 : 32'b10);
      chk("t3_rdata", (i % 2 == 0) ? a_m0_rdata : a_m1_rdata,
          (i % 2 == 0) ? 32'h1000_0001 : 32'h1000_0002);
      if (i == 3) begin a_m0_valid = 1'b0; a_m1_valid = 1'b0; end
      cyc();
      chk("t3_ready_drop", {30'd0, a_m1_ready, a_m0_ready}, 32'd0);
    end
    // T5: m1 partial write then m0 reads the word back
    a_m1_valid = 1'b1; a_m1_addr = 32'h20; a_m1_wdata = 32'hDEAD_BEEF; a_m1_wmask = 4'b0011;
    cyc();
    chk("t5_wmask", {27'd0, a_rstrb, a_wmask}, 32'b00011);
    chk("t5_wdata", a_mem_wdata, 32'hDEAD_BEEF);
    chk("t5_gnt", {30'd0, a_gnt}, 32'b10);
    cyc();
    chk("t5_ready", {27'd0, a_rstrb, a_wmask, a_m1_ready}, 32'b1);
    a_m1_valid = 1'b0;
    cyc();
    a_m0_valid = 1'b1; a_m0_addr = 32'h20;
    cyc();
    chk("t5_read_strobe", {31'd0, a_rstrb}, 32'd1);
    cyc();
    chk("t5_readback", a_m0_rdata, 32'h1000_BEEF);
    a_m0_valid = 1'b0;
    // T4: fixed priority starves m1 while m0 stays valid
    b_rst = 1'b1; b_m0_valid = 1'b1; b_m1_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc();
      chk("t4_no_m1", {30'd0, b_gnt[1], b_m1_ready}, 32'd0);
    end
    for (int i = 0; i < 8 && !b_m0_ready; i++) cyc();
    chk("t4_m0_ready_seen", {31'd0, b_m0_ready}, 32'd1);
    chk("t4_m0_rdata", b_m0_rdata, 32'hCAFE_0100);
    b_m0_valid = 1'b0;
    cyc();
    chk("t4_ready_edge_no_grant", {30'd0, b_gnt}, 32'd0);
    cyc();
    chk("t4_m1_gnt", {30'd0, b_gnt}, 32'b10);
    chk("t4_m1_addr", b_mem_addr, 32'h200);
    cyc();
    cyc();
    chk("t4_m1_wait", {31'd0, b_m1_ready}, 32'd0);
    cyc();
    chk("t4_m1_ready", {31'd0, b_m1_ready}, 32'd1);
    chk("t4_m1_rdata", b_m1_rdata, 32'hCAFE_0200);
    b_m1_valid = 1'b0;
    cyc();
    // T6: reset during WAIT aborts, then a fresh read completes
    b_m0_valid = 1'b1; b_m0_addr = 32'h44;
    cyc();
    chk("t6_busy", {31'd0, b_busy}, 32'd1);
    cyc();
    b_rst = 1'b0;
    cyc();
    chk("t6_abort", {26'd0, b_rstrb, b_m0_ready, b_m1_ready, b_busy, b_gnt}, 32'd0);
    b_rst = 1'b1; b_m0_addr = 32'h48;
    cyc();
    chk("t6_regrant", {30'd0, b_gnt}, 32'b01);
    chk("t6_addr", b_mem_addr, 32'h48);
    cyc();
    chk("t6_wait1", {31'd0, b_m0_ready}, 32'd0);
    cyc();
    chk("t6_wait2", {31'd0, b_m0_ready}, 32'd0);
    cyc();
    chk("t6_ready", {31'd0, b_m0_ready}, 32'd1);
    chk("t6_rdata", b_m0_rdata, 32'hCAFE_0048);
    b_m0_valid = 1'b0;
    cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
